// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer over a word-addressed memory with byte
// strobes, programmable wait states and address-error reporting.
//
// Parameters: ADDR_WIDTH (PADDR bits), DATA_WIDTH (8/16/32), DEPTH (words),
//             WAIT_CYCLES (0..15 wait states per transfer).
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   synchronous active-low reset
//   PSEL     in   completer select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   byte write strobes
//   PRDATA   out  read data, nonzero only in the completing cycle
//   PREADY   out  one-cycle transfer completion
//   PSLVERR  out  error flag, valid with PREADY
// Build option: APB_SLAVE_WAIT_EN -- when defined the wait counter is built
// and WAIT_CYCLES is honoured; otherwise every transfer takes 2 cycles.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int SH = $clog2(NB);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("apb_slave_mem: WAIT_CYCLES must be 0..15");
   end
   if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
      $error("apb_slave_mem: DATA_WIDTH must be 8, 16 or 32");
   end

   // The APB setup cycle is the cycle in which the FSM sits in IDLE and
   // samples PSEL & !PENABLE; ACCESS covers the access phase (T1 onward).
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                  r_state;
   logic [IW-1:0]           r_idx;
   logic                    r_wr;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [NB-1:0]           r_strb;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_ready;
   logic                    r_slverr;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
`ifdef APB_SLAVE_WAIT_EN
   logic [3:0]              r_cnt;
`endif

   logic [31:0]             w_word;
   logic                    w_mis;
   logic                    w_err;
   logic [IW-1:0]           w_idx;
   logic [IW-1:0]           w_sel_idx;
   logic                    w_sel_wr;
   logic                    w_sel_err;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   assign w_word = 32'(PADDR >> SH);
   assign w_mis  = |(PADDR & ADDR_WIDTH'(NB - 1));
   assign w_err  = (w_word >= 32'(DEPTH)) | w_mis;
   assign w_idx  = w_word[IW-1:0];

   // Outputs are registered, so the response is prepared one edge early:
   // from the live bus when completing straight out of setup, otherwise
   // from the captured transfer.
   always_comb begin
      w_sel_idx = r_idx;
      w_sel_wr  = r_wr;
      w_sel_err = r_err;
      if (r_state == ST_IDLE) begin
         w_sel_idx = w_idx;
         w_sel_wr  = PWRITE;
         w_sel_err = w_err;
      end
      w_rd_word = '0;
      if (!w_sel_wr && !w_sel_err) begin
         w_rd_word = r_mem[w_sel_idx];
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_wr     <= 1'b0;
         r_err    <= 1'b0;
         r_wdata  <= '0;
         r_strb   <= '0;
         r_rdata  <= '0;
         r_ready  <= 1'b0;
         r_slverr <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
         r_cnt    <= '0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_ready  <= 1'b0;
         r_slverr <= 1'b0;
         r_rdata  <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_state <= ST_ACCESS;
                  r_idx   <= w_idx;
                  r_wr    <= PWRITE;
                  r_err   <= w_err;
                  r_wdata <= PWDATA;
                  r_strb  <= PSTRB;
`ifdef APB_SLAVE_WAIT_EN
                  r_cnt   <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     r_ready  <= 1'b1;
                     r_slverr <= w_sel_err;
                     r_rdata  <= w_rd_word;
                  end
`else
                  r_ready  <= 1'b1;
                  r_slverr <= w_sel_err;
                  r_rdata  <= w_rd_word;
`endif
               end
            end
            ST_ACCESS: begin
               if (r_ready) begin
                  // Completing edge: commit only if the requester is
                  // still in the access phase.
                  r_state <= ST_IDLE;
                  if (PSEL && PENABLE && r_wr && !r_err) begin
                     for (int b = 0; b < NB; b++) begin
                        if (r_strb[b]) begin
                           r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                     end
                  end
               end else if (!PSEL) begin
                  r_state <= ST_IDLE;
`ifdef APB_SLAVE_WAIT_EN
                  r_cnt   <= '0;
`endif
               end else begin
`ifdef APB_SLAVE_WAIT_EN
                  if (r_cnt != 4'd0) begin
                     r_cnt <= r_cnt - 4'd1;
                  end
                  if (r_cnt == 4'd1) begin
                     r_ready  <= 1'b1;
                     r_slverr <= w_sel_err;
                     r_rdata  <= w_rd_word;
                  end
`else
                  r_state <= ST_IDLE;
`endif
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign PRDATA  = r_rdata;
   assign PREADY  = r_ready;
   assign PSLVERR = r_slverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed and randomized APB transfers checked against
// a word-array reference model with expected latency and error rules.
module tb_apb_slave_mem;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int DP = 64;
   localparam int WC = 2;
`ifdef APB_SLAVE_WAIT_EN
   localparam int W_EFF = WC;
`else
   localparam int W_EFF = 0;
`endif

   logic          PCLK;
   logic          PRESETn;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [3:0]    PSTRB;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   int n_cmp;
   int n_bad;
   logic [31:0] model [DP];
   logic [31:0] last_rd;

   apb_slave_mem #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DP),
      .WAIT_CYCLES(WC)
   ) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PSTRB  (PSTRB),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DP; i++) model[i] = 32'h0;
   endtask

   // Called #1 after a rising edge; that cycle becomes the setup cycle T0.
   // Returns #1 after the edge following completion with the bus idle.
   task automatic xfer(input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      int c;
      int idx;
      logic e_err;
      logic [31:0] e_rd;
      idx   = int'(a) / 4;
      e_err = (idx >= DP) || (a % 4 != 0);
      e_rd  = (wr || e_err) ? 32'h0 : model[idx];
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
      PADDR = a; PWDATA = d; PSTRB = s;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      c = 0;
      while (!PREADY && c < W_EFF + 4) begin
         @(posedge PCLK); #1;
         c++;
      end
      chk("latency", 32'(c), 32'(W_EFF));
      chk("pslverr", 32'(PSLVERR), 32'(e_err));
      chk("prdata", PRDATA, e_rd);
      last_rd = PRDATA;
      if (wr && !e_err) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("ready_one_cycle", 32'(PREADY), 32'h0);
      chk("prdata_idle", PRDATA, 32'h0);
   endtask

   initial begin
      logic [AW-1:0] a;
      int r;
      n_cmp = 0; n_bad = 0; last_rd = '0;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0;
      model_clear();
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_prdata", PRDATA, 32'h0);
      chk("rst_pready", 32'(PREADY), 32'h0);
      chk("rst_pslverr", 32'(PSLVERR), 32'h0);
      PRESETn = 1'b1;

      xfer(1'b0, 9'h000, 32'h0, 4'h0);
      chk("read0", last_rd, 32'h0);

      xfer(1'b1, 9'h010, 32'hDEADBEEF, 4'b0101);
      xfer(1'b0, 9'h010, 32'h0, 4'hF);
      chk("strobe_read", last_rd, 32'h00AD00EF);

      xfer(1'b0, 9'h100, 32'h0, 4'h0);
      xfer(1'b1, 9'h002, 32'h12345678, 4'hF);
      xfer(1'b0, 9'h000, 32'h0, 4'h0);
      chk("misaligned_no_write", last_rd, 32'h0);

      // Access phase with no setup: must be ignored.
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
      PADDR = 9'h00C; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         chk("no_setup_ready", 32'(PREADY), 32'h0);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      xfer(1'b0, 9'h00C, 32'h0, 4'h0);

`ifdef APB_SLAVE_WAIT_EN
      // Abort a write by dropping PSEL in the second access cycle.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 9'h020; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      chk("abort_t1_ready", 32'(PREADY), 32'h0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("abort_ready", 32'(PREADY), 32'h0);
         @(posedge PCLK); #1;
      end
      xfer(1'b0, 9'h020, 32'h0, 4'h0);
`endif

      // Reset during the access phase of a write to word 1.
      xfer(1'b1, 9'h004, 32'hAAAA5555, 4'hF);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 9'h004; PWDATA = 32'h11111111; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("rst_mid_prdata", PRDATA, 32'h0);
      chk("rst_mid_pready", 32'(PREADY), 32'h0);
      chk("rst_mid_pslverr", 32'(PSLVERR), 32'h0);
      model_clear();
      PRESETn = 1'b1;
      xfer(1'b0, 9'h004, 32'h0, 4'h0);
      chk("word1_after_rst", last_rd, 32'h0);

      // Back-to-back write then read.
      xfer(1'b1, 9'h008, 32'h0BADF00D, 4'hF);
      xfer(1'b0, 9'h008, 32'h0, 4'h0);
      chk("b2b_read", last_rd, 32'h0BADF00D);

      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) a = AW'({$urandom_range(0, DP - 1), 2'b00});
         else if (r == 7) a = AW'({$urandom_range(0, DP - 1), 2'b00} | $urandom_range(1, 3));
         else a = AW'($urandom_range(0, 511));
         xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
